// File: rtl/seq_arithmetic_unit.sv
// Multi-cycle arithmetic unit: add/sub, radix-4 Booth multiply, non-restoring divide, negate.
// A single FSM sequences both iterative engines behind a start/done handshake.
module seq_arithmetic_unit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] arith_in,
  input  logic [2:0]         arith_lines,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] arith_out
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(W/2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W:0]      mplier_q, mplier_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W+1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dvsr_q, dvsr_d;
  logic            negq_q, negq_d, negr_q, negr_d;
  logic            busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [2*W-1:0]  out_q, out_d;

  logic [W-1:0]    op1, op2, abs1, abs2;
  logic [2*W-1:0]  ext1, ext2;
  logic            accept;

  assign op1    = arith_in[2*W-1:W];
  assign op2    = arith_in[W-1:0];
  assign ext1   = {{W{op1[W-1]}}, op1};
  assign ext2   = {{W{op2[W-1]}}, op2};
  assign abs1   = op1[W-1] ? -op1 : op1;
  assign abs2   = op2[W-1] ? -op2 : op2;
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  // Booth digit from {b[2i+1], b[2i], b[2i-1]}; multiplicand pre-shifted by 2i.
  logic [2*W-1:0] pp, acc_nxt;
  always_comb begin
    pp = '0;
    case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    acc_nxt = acc_q + pp;
  end

  // Non-restoring step on magnitudes; quotient bit is 1 whenever the new partial remainder is non-negative.
  logic [W+1:0] shifted, dext, rem_nxt;
  logic [W-1:0] r_mag, q_fin, r_fin;
  always_comb begin
    shifted = {rem_q[W:0], quo_q[W-1]};
    dext    = {2'b00, dvsr_q};
    rem_nxt = rem_q[W+1] ? shifted + dext : shifted - dext;
    r_mag   = rem_q[W+1] ? rem_q[W-1:0] + dvsr_q : rem_q[W-1:0];
    q_fin   = negq_q ? -quo_q : quo_q;
    r_fin   = negr_q ? -r_mag : r_mag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dbz_d    = dbz_q;
    out_d    = out_q;

    case (state_q)
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 2;
        mplier_d = {{2{mplier_q[W]}}, mplier_q[W:2]};
        if (cnt_q == '0) begin
          state_d = S_DONE;
          out_d   = acc_nxt;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        rem_d = rem_nxt;
        quo_d = {quo_q[W-2:0], ~rem_nxt[W+1]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        state_d = S_DONE;
        out_d   = {q_fin, r_fin};
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    // An accept in the DONE cycle overrides the return to IDLE.
    if (accept) begin
      dbz_d = 1'b0;
      case (arith_lines[1:0])
        2'b00: begin
          out_d   = arith_lines[2] ? ext1 - ext2 : ext1 + ext2;
          state_d = S_DONE;
        end
        2'b01: begin
          mcand_d  = ext1;
          mplier_d = {op2, 1'b0};
          acc_d    = '0;
          cnt_d    = MUL_LAST;
          state_d  = S_MUL;
        end
        2'b10: begin
          if (op2 == '0) begin
            out_d   = {{W{1'b1}}, op1};
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = abs1;
            dvsr_d  = abs2;
            negq_d  = op1[W-1] ^ op2[W-1];
            negr_d  = op1[W-1];
            cnt_d   = DIV_LAST;
            state_d = S_DIV;
          end
        end
        default: begin
          out_d   = {-op1, -op2};
          state_d = S_DONE;
        end
      endcase
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      out_q    <= out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign arith_out   = out_q;
endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// Directed bench for seq_arithmetic_unit: a 16-bit and an 8-bit instance share clock and reset.
module tb_seq_arithmetic_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start8;
  logic [31:0] in16;
  logic [15:0] in8;
  logic [2:0]  lines16, lines8;
  logic        busy16, done16, dbz16, busy8, done8, dbz8;
  logic [31:0] out16;
  logic [15:0] out8;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  seq_arithmetic_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .arith_in(in16), .arith_lines(lines16),
    .busy(busy16), .done(done16), .div_by_zero(dbz16), .arith_out(out16)
  );

  seq_arithmetic_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .arith_in(in8), .arith_lines(lines8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .arith_out(out8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one 16-bit op; scramble inputs right after accept, optionally pulse start while busy.
  task automatic op16(input string tag, input logic [2:0] ln, input logic [15:0] a,
                      input logic [15:0] b, input logic [31:0] exp, input int lat,
                      input logic dbz, input bit poke);
    int n; bit seen; logic b1;
    @(negedge clk);
    lines16 = ln; in16 = {a, b}; start16 = 1'b1;
    n = 0; seen = 1'b0; b1 = 1'b0;
    while (!seen && n < 64) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        b1 = busy16; start16 = 1'b0; in16 = ~in16; lines16 = ~ln;
      end
      if (poke && n == 3) begin start16 = 1'b1; in16 = 32'h0001_0001; lines16 = 3'b000; end
      if (poke && n == 4) start16 = 1'b0;
      if (done16) seen = 1'b1;
    end
    chk({tag, "_lat"}, seen ? n : -1, lat);
    chk({tag, "_busy"}, {63'd0, b1}, {63'd0, lat > 1});
    chk({tag, "_out"}, {32'd0, out16}, {32'd0, exp});
    chk({tag, "_dbz"}, {63'd0, dbz16}, {63'd0, dbz});
  endtask

  task automatic op8(input string tag, input logic [2:0] ln, input logic [7:0] a,
                     input logic [7:0] b, input logic [15:0] exp, input int lat);
    int n; bit seen;
    @(negedge clk);
    lines8 = ln; in8 = {a, b}; start8 = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 64) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin start8 = 1'b0; in8 = ~in8; end
      if (done8) seen = 1'b1;
    end
    chk({tag, "_lat"}, seen ? n : -1, lat);
    chk({tag, "_out"}, {48'd0, out8}, {48'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst = 1'b1; start16 = 1'b0; start8 = 1'b0;
    in16 = '0; in8 = '0; lines16 = '0; lines8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",  {32'd0, out16}, 64'd0);
    chk("rst_flags", {61'd0, busy16, done16, dbz16}, 64'd0);
    @(negedge clk) rst = 1'b0;

    op16("add",    3'b000, 16'h0064, 16'hFFE2, 32'h0000_0046, 1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse", {63'd0, done16}, 64'd0);
    chk("out_hold", {32'd0, out16}, 64'h46);
    op16("sub",    3'b100, 16'h0005, 16'h0007, 32'hFFFF_FFFE, 1, 1'b0, 1'b0);
    op16("addmin", 3'b000, 16'h8000, 16'h8000, 32'hFFFF_0000, 1, 1'b0, 1'b0);
    op16("submax", 3'b100, 16'h7FFF, 16'h8000, 32'h0000_FFFF, 1, 1'b0, 1'b0);
    op16("mul",    3'b001, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, 9, 1'b0, 1'b1);
    op16("mulmin", 3'b001, 16'h8000, 16'h8000, 32'h4000_0000, 9, 1'b0, 1'b0);
    op16("mulmix", 3'b001, 16'h7FFF, 16'h8000, 32'hC000_8000, 9, 1'b0, 1'b0);
    op16("div",    3'b010, 16'hFFF9, 16'h0002, 32'hFFFD_FFFF, 18, 1'b0, 1'b0);
    op16("divwrap",3'b010, 16'h8000, 16'hFFFF, 32'h8000_0000, 18, 1'b0, 1'b0);
    op16("divneg", 3'b010, 16'h0064, 16'hFFF9, 32'hFFF2_0002, 18, 1'b0, 1'b0);
    op16("div0",   3'b010, 16'h04D2, 16'h0000, 32'hFFFF_04D2, 1, 1'b1, 1'b0);
    op16("clrdbz", 3'b000, 16'h0001, 16'h0001, 32'h0000_0002, 1, 1'b0, 1'b0);
    op16("neg",    3'b011, 16'h8000, 16'h0005, 32'h8000_FFFB, 1, 1'b0, 1'b0);

    // Reset during a multiply: outputs clear at once and no done follows.
    @(negedge clk);
    lines16 = 3'b001; in16 = {16'h0002, 16'h0003}; start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rstmid_out", {32'd0, out16}, 64'd0);
    chk("rstmid_flags", {61'd0, busy16, done16, dbz16}, 64'd0);
    @(negedge clk) rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done16) saw = 1'b1;
    end
    chk("rstmid_nodone", {63'd0, saw}, 64'd0);

    op8("mul8", 3'b001, 8'h7F, 8'h80, 16'hC080, 5);
    op8("div8", 3'b010, 8'h80, 8'h03, 16'hD6FE, 10);
    op8("add8", 3'b000, 8'h7F, 8'h7F, 16'h00FE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
